// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit and the RAM it drives.
// Holds the memory op encodings, the response error codes, the LSU state
// encoding, and a helper that sign/zero-extends right-aligned load data.
package lsu_pkg;

    // Bit 3 set marks a store.
    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LW   = 4'd3,
        MEM_LBU  = 4'd4,
        MEM_LHU  = 4'd5,
        MEM_SB   = 4'd9,
        MEM_SH   = 4'd10,
        MEM_SW   = 4'd11
    } mem_op_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_RANGE    = 2'b10,
        ERR_TIMEOUT  = 2'b11
    } resp_err_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    // Load data arrives right-aligned; widen it according to the op.
    function automatic logic [31:0] load_extend(input mem_op_e op, input logic [31:0] d);
        case (op)
            MEM_LB:  return {{24{d[7]}}, d[7:0]};
            MEM_LH:  return {{16{d[15]}}, d[15:0]};
            MEM_LBU: return {24'd0, d[7:0]};
            MEM_LHU: return {16'd0, d[15:0]};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/lsu_req_check.sv
// Combinational request classifier for the LSU.
// Ports:
//   op           raw 4-bit op from the pipeline
//   addr         byte address
//   op_norm      op with undefined codes mapped to MEM_NONE
//   misaligned   address not aligned to the access size
//   out_of_range address has bits set at or above RAM_ADDR_BITS
module lsu_req_check
    import lsu_pkg::*;
#(
    parameter int RAM_ADDR_BITS = 7
) (
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    output mem_op_e     op_norm,
    output logic        misaligned,
    output logic        out_of_range
);

    always_comb begin
        op_norm    = MEM_NONE;
        misaligned = 1'b0;
        case (op)
            MEM_LB, MEM_LBU, MEM_SB: begin
                op_norm = mem_op_e'(op);
            end
            MEM_LH, MEM_LHU, MEM_SH: begin
                op_norm    = mem_op_e'(op);
                misaligned = addr[0];
            end
            MEM_LW, MEM_SW: begin
                op_norm    = mem_op_e'(op);
                misaligned = |addr[1:0];
            end
            default: ;
        endcase
    end

    // NONE never reports a range error; it always answers ok.
    assign out_of_range = (op_norm != MEM_NONE) && (|(addr >> RAM_ADDR_BITS));

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one pipeline memory request at a time, checks it,
// drives the RAM for a single access and returns a response with an error code.
// Ports:
//   clk, rst                      clock, async active-high reset
//   req_valid/req_ready           request handshake (ready only in IDLE)
//   req_op/req_addr/req_wdata     request op, byte address, right-aligned store data
//   resp_valid/resp_ready         response handshake
//   resp_rdata/resp_err           extended load data (0 otherwise), error code
//   ram_mem_ctrl                  op to the RAM, NONE outside ACCESS
//   ram_rd_addr/ram_wr_addr       RAM addresses
//   ram_wr_data                   RAM write data
//   ram_rd_ready/ram_rd_data      RAM read data valid (same cycle) and data
//   ram_wr_ready                  RAM write done, cycle after the write edge
//
// state  | meaning
// IDLE   | ready for a request
// ACCESS | op presented to the RAM (loads wait here for read ready)
// WAIT   | store issued, waiting for write ready
// RESP   | response held until resp_ready
module lsu
    import lsu_pkg::*;
#(
    parameter int RAM_ADDR_BITS = 7,
    parameter int TIMEOUT       = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err,
    output logic [3:0]  ram_mem_ctrl,
    output logic [31:0] ram_rd_addr,
    output logic [31:0] ram_wr_addr,
    output logic [31:0] ram_wr_data,
    input  logic        ram_rd_ready,
    input  logic        ram_wr_ready,
    input  logic [31:0] ram_rd_data
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_e       state;
    mem_op_e          op_q;
    logic [CNT_W-1:0] wait_cnt;

    mem_op_e chk_op;
    logic    chk_misaligned;
    logic    chk_out_of_range;

    lsu_req_check #(.RAM_ADDR_BITS(RAM_ADDR_BITS)) u_req_check (
        .op           (req_op),
        .addr         (req_addr),
        .op_norm      (chk_op),
        .misaligned   (chk_misaligned),
        .out_of_range (chk_out_of_range)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            op_q         <= MEM_NONE;
            wait_cnt     <= '0;
            req_ready    <= 1'b0;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_err     <= ERR_OK;
            ram_mem_ctrl <= MEM_NONE;
            ram_rd_addr  <= '0;
            ram_wr_addr  <= '0;
            ram_wr_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready   <= 1'b0;
                        op_q        <= chk_op;
                        ram_rd_addr <= req_addr;
                        ram_wr_addr <= req_addr;
                        ram_wr_data <= req_wdata;
                        resp_rdata  <= '0;
                        if (chk_op == MEM_NONE) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= ERR_OK;
                        end else if (chk_misaligned) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= ERR_MISALIGN;
                        end else if (chk_out_of_range) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= ERR_RANGE;
                        end else begin
                            state        <= ST_ACCESS;
                            ram_mem_ctrl <= chk_op;
                            wait_cnt     <= '0;
                        end
                    end else begin
                        // Covers the first cycle after reset release.
                        req_ready <= 1'b1;
                    end
                end

                ST_ACCESS: begin
                    if (op_q[3]) begin
                        // Stores see exactly one write edge.
                        state        <= ST_WAIT;
                        ram_mem_ctrl <= MEM_NONE;
                    end else if (ram_rd_ready) begin
                        // Ready beats a timeout reached in the same cycle.
                        state        <= ST_RESP;
                        ram_mem_ctrl <= MEM_NONE;
                        resp_valid   <= 1'b1;
                        resp_rdata   <= load_extend(op_q, ram_rd_data);
                        resp_err     <= ERR_OK;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state        <= ST_RESP;
                        ram_mem_ctrl <= MEM_NONE;
                        wait_cnt     <= wait_cnt + CNT_W'(1);
                        resp_valid   <= 1'b1;
                        resp_rdata   <= '0;
                        resp_err     <= ERR_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                ST_WAIT: begin
                    if (ram_wr_ready) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= ERR_OK;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state      <= ST_RESP;
                        wait_cnt   <= wait_cnt + CNT_W'(1);
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= ERR_TIMEOUT;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                ST_RESP: begin
                    if (resp_ready) begin
                        state      <= ST_IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        resp_rdata <= '0;
                        resp_err   <= ERR_OK;
                    end
                end

                default: begin
                    state        <= ST_IDLE;
                    ram_mem_ctrl <= MEM_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LH = 4'd2, OP_LW = 4'd3,
                           OP_LBU = 4'd4, OP_LHU = 4'd5, OP_SB = 4'd9, OP_SH = 4'd10,
                           OP_SW = 4'd11;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;
    logic [3:0]  ram_mem_ctrl;
    logic [31:0] ram_rd_addr;
    logic [31:0] ram_wr_addr;
    logic [31:0] ram_wr_data;
    logic        ram_rd_ready;
    logic        ram_wr_ready;
    logic [31:0] ram_rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    lsu #(.RAM_ADDR_BITS(7), .TIMEOUT(15)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .ram_mem_ctrl (ram_mem_ctrl),
        .ram_rd_addr  (ram_rd_addr),
        .ram_wr_addr  (ram_wr_addr),
        .ram_wr_data  (ram_wr_data),
        .ram_rd_ready (ram_rd_ready),
        .ram_wr_ready (ram_wr_ready),
        .ram_rd_data  (ram_rd_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- RAM model ----------------
    logic [7:0] mem [0:127];
    logic       rd_en = 1'b1;
    logic       wr_en = 1'b1;
    logic       pre_we = 1'b0;
    logic [6:0] pre_addr = '0;
    logic [7:0] pre_data = '0;
    logic       wr_ready_q = 1'b0;
    int         sh_cycles = 0;
    int         ctrl_cycles = 0;
    logic [6:0] wa;
    logic [6:0] ra;

    assign wa = ram_wr_addr[6:0];
    assign ra = ram_rd_addr[6:0];

    always @(posedge clk) begin
        if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end else begin
            case (ram_mem_ctrl)
                OP_SB: mem[wa] <= ram_wr_data[7:0];
                OP_SH: begin
                    mem[wa]        <= ram_wr_data[7:0];
                    mem[wa + 7'd1] <= ram_wr_data[15:8];
                end
                OP_SW: begin
                    mem[wa]        <= ram_wr_data[7:0];
                    mem[wa + 7'd1] <= ram_wr_data[15:8];
                    mem[wa + 7'd2] <= ram_wr_data[23:16];
                    mem[wa + 7'd3] <= ram_wr_data[31:24];
                end
                default: ;
            endcase
        end
        wr_ready_q <= wr_en && (ram_mem_ctrl == OP_SB || ram_mem_ctrl == OP_SH || ram_mem_ctrl == OP_SW);
        if (ram_mem_ctrl == OP_SH) sh_cycles <= sh_cycles + 1;
        if (ram_mem_ctrl != OP_NONE) ctrl_cycles <= ctrl_cycles + 1;
    end

    assign ram_wr_ready = wr_ready_q;
    assign ram_rd_ready = rd_en && (ram_mem_ctrl == OP_LB || ram_mem_ctrl == OP_LH ||
                          ram_mem_ctrl == OP_LW || ram_mem_ctrl == OP_LBU || ram_mem_ctrl == OP_LHU);

    always_comb begin
        ram_rd_data = 32'd0;
        case (ram_mem_ctrl)
            OP_LB, OP_LBU: ram_rd_data = {24'd0, mem[ra]};
            OP_LH, OP_LHU: ram_rd_data = {16'd0, mem[ra + 7'd1], mem[ra]};
            OP_LW:         ram_rd_data = {mem[ra + 7'd3], mem[ra + 7'd2], mem[ra + 7'd1], mem[ra]};
            default: ;
        endcase
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [6:0] a, input logic [7:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        tick();
        pre_we = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) begin
            n_checks++; n_fail++;
            $display("FAIL issue_ready: req_ready got %b expected 1", req_ready);
        end
        req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = d;
        tick();
        req_valid = 1'b0;
    endtask

    // Latency counted as in "resp_valid from N+k": 1 means visible right after the acceptance edge.
    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2 rst = 1'b1;
        tick();
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b expected 0", req_ready); end
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b expected 0", resp_valid); end
        n_checks++; if (ram_mem_ctrl !== 4'd0) begin n_fail++; $display("FAIL rst_mem_ctrl: got %h expected 0", ram_mem_ctrl); end
        n_checks++; if (resp_rdata !== 32'd0 || resp_err !== 2'd0) begin n_fail++; $display("FAIL rst_resp: got %h/%b expected 0/00", resp_rdata, resp_err); end
        n_checks++; if (ram_wr_addr !== 32'd0 || ram_rd_addr !== 32'd0 || ram_wr_data !== 32'd0) begin n_fail++; $display("FAIL rst_ram_bus: got %h %h %h expected zeros", ram_rd_addr, ram_wr_addr, ram_wr_data); end
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_req_ready: got %b expected 1", req_ready); end
    endtask

    task automatic test_load_word();
        int lat;
        rd_en = 1'b1;
        issue(OP_LW, 32'h10, 32'h0);
        n_checks++; if (ram_mem_ctrl !== OP_LW) begin n_fail++; $display("FAIL lw_mem_ctrl: got %h expected %h", ram_mem_ctrl, OP_LW); end
        wait_resp(lat);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL lw_latency: got %0d expected 2", lat); end
        n_checks++; if (resp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_rdata: got %h expected deadbeef", resp_rdata); end
        n_checks++; if (resp_err !== 2'b00) begin n_fail++; $display("FAIL lw_err: got %b expected 00", resp_err); end
        n_checks++; if (ram_mem_ctrl !== OP_NONE) begin n_fail++; $display("FAIL lw_ctrl_resp: got %h expected 0", ram_mem_ctrl); end
        finish_resp();
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL lw_return_idle: got valid %b ready %b expected 0 1", resp_valid, req_ready); end
    endtask

    task automatic test_store_half();
        int lat;
        int sh0;
        sh0 = sh_cycles;
        issue(OP_SH, 32'h20, 32'h1234ABCD);
        wait_resp(lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL sh_latency: got %0d expected 3", lat); end
        n_checks++; if (resp_err !== 2'b00 || resp_rdata !== 32'd0) begin n_fail++; $display("FAIL sh_resp: got %b/%h expected 00/0", resp_err, resp_rdata); end
        n_checks++; if (sh_cycles - sh0 !== 1) begin n_fail++; $display("FAIL sh_ctrl_cycles: got %0d expected 1", sh_cycles - sh0); end
        n_checks++; if ({mem[34], mem[33], mem[32]} !== 24'h55ABCD) begin n_fail++; $display("FAIL sh_mem: got %h expected 55abcd", {mem[34], mem[33], mem[32]}); end
        finish_resp();
        issue(OP_LHU, 32'h20, 32'h0);
        wait_resp(lat);
        n_checks++; if (lat !== 2 || resp_rdata !== 32'h0000ABCD) begin n_fail++; $display("FAIL lhu_rdata: got lat %0d data %h expected 2 0000abcd", lat, resp_rdata); end
        finish_resp();
    endtask

    task automatic test_sign_ext();
        int lat;
        issue(OP_SB, 32'h30, 32'h00000085);
        wait_resp(lat);
        finish_resp();
        issue(OP_LB, 32'h30, 32'h0);
        wait_resp(lat);
        n_checks++; if (resp_rdata !== 32'hFFFFFF85) begin n_fail++; $display("FAIL lb_sext: got %h expected ffffff85", resp_rdata); end
        finish_resp();
        issue(OP_LBU, 32'h30, 32'h0);
        wait_resp(lat);
        n_checks++; if (resp_rdata !== 32'h00000085) begin n_fail++; $display("FAIL lbu_zext: got %h expected 00000085", resp_rdata); end
        finish_resp();
        issue(OP_LH, 32'h30, 32'h0);
        wait_resp(lat);
        n_checks++; if (resp_rdata !== 32'hFFFFF085) begin n_fail++; $display("FAIL lh_sext: got %h expected fffff085", resp_rdata); end
        finish_resp();
    endtask

    task automatic test_errors();
        logic [3:0]  ops  [5] = '{OP_LW, OP_LB, OP_SH, OP_NONE, 4'd7};
        logic [31:0] adrs [5] = '{32'h02, 32'h80, 32'h81, 32'h200, 32'h04};
        logic [1:0]  errs [5] = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b00};
        int lat;
        int c0;
        c0 = ctrl_cycles;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], adrs[i], 32'hFFFFFFFF);
            wait_resp(lat);
            n_checks++;
            if (lat !== 1 || resp_err !== errs[i] || resp_rdata !== 32'd0) begin
                n_fail++;
                $display("FAIL err_case%0d: got lat %0d err %b data %h expected 1 %b 0", i, lat, resp_err, resp_rdata, errs[i]);
            end
            finish_resp();
        end
        n_checks++; if (ctrl_cycles - c0 !== 0) begin n_fail++; $display("FAIL err_no_ram_access: got %0d ctrl cycles expected 0", ctrl_cycles - c0); end
    endtask

    task automatic test_timeout();
        int lat;
        rd_en = 1'b0;
        issue(OP_LW, 32'h10, 32'h0);
        wait_resp(lat);
        n_checks++; if (lat !== 16 || resp_err !== 2'b11 || resp_rdata !== 32'd0) begin n_fail++; $display("FAIL timeout: got lat %0d err %b data %h expected 16 11 0", lat, resp_err, resp_rdata); end
        finish_resp();
        rd_en = 1'b1;
        issue(OP_LW, 32'h10, 32'h0);
        wait_resp(lat);
        n_checks++; if (lat !== 2 || resp_rdata !== 32'hDEADBEEF || resp_err !== 2'b00) begin n_fail++; $display("FAIL after_timeout: got lat %0d data %h err %b expected 2 deadbeef 00", lat, resp_rdata, resp_err); end
        finish_resp();
    endtask

    task automatic test_ready_at_timeout();
        rd_en = 1'b0;
        issue(OP_LW, 32'h10, 32'h0);
        for (int i = 0; i < 14; i++) tick();
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL edge_early_resp: got %b expected 0", resp_valid); end
        rd_en = 1'b1;
        tick();
        n_checks++; if (resp_valid !== 1'b1 || resp_err !== 2'b00 || resp_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL edge_ready_wins: got v %b err %b data %h expected 1 00 deadbeef", resp_valid, resp_err, resp_rdata); end
        finish_resp();
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        issue(OP_LHU, 32'h20, 32'h0);
        wait_resp(lat);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h0000ABCD || resp_err !== 2'b00 || req_ready !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL backpressure_hold: got %0d unstable cycles expected 0", bad); end
        finish_resp();
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin n_fail++; $display("FAIL backpressure_release: got v %b r %b expected 0 1", resp_valid, req_ready); end
    endtask

    task automatic test_reset_mid_store();
        issue(OP_SW, 32'h40, 32'hCAFEF00D);
        n_checks++; if (ram_mem_ctrl !== OP_SW) begin n_fail++; $display("FAIL sw_in_access: got %h expected %h", ram_mem_ctrl, OP_SW); end
        rst = 1'b1;
        #1;
        n_checks++; if (ram_mem_ctrl !== 4'd0 || ram_wr_data !== 32'd0 || ram_wr_addr !== 32'd0) begin n_fail++; $display("FAIL rst_mid_bus: got %h %h %h expected zeros", ram_mem_ctrl, ram_wr_addr, ram_wr_data); end
        n_checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_hs: got v %b r %b expected 0 0", resp_valid, req_ready); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_checks++; if ({mem[67], mem[66], mem[65], mem[64]} !== 32'h44332211) begin n_fail++; $display("FAIL rst_mid_mem: got %h expected 44332211", {mem[67], mem[66], mem[65], mem[64]}); end
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b expected 1", req_ready); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        test_reset();
        preload(7'h10, 8'hEF); preload(7'h11, 8'hBE); preload(7'h12, 8'hAD); preload(7'h13, 8'hDE);
        preload(7'h22, 8'h55); preload(7'h31, 8'hF0);
        preload(7'h40, 8'h11); preload(7'h41, 8'h22); preload(7'h42, 8'h33); preload(7'h43, 8'h44);
        test_load_word();
        test_store_half();
        test_sign_ext();
        test_errors();
        test_timeout();
        test_ready_at_timeout();
        test_backpressure();
        test_reset_mid_store();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
